// File: rtl/clock_phase_gen_pkg.sv
// rtl/clock_phase_gen_pkg.sv - shared types and helpers for the phase clock generator
// Contents:
//   state_e  controller state (IDLE, RUN, STEP)
//   DIV_MIN  smallest divide ratio the counter is allowed to use
//   mod_sub  (a - b) mod m for operands already reduced below m
package clock_phase_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  localparam int DIV_MIN = 2;

  // Operands are carried at 32 bits so a + m cannot overflow; callers
  // truncate the result back to the counter width.
  function automatic logic [31:0] mod_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] m);
    if (a >= b) return a - b;
    else        return a + m - b;
  endfunction

endpackage

// File: rtl/clock_phase_chan.sv
// rtl/clock_phase_chan.sv - one derived clock channel with phase offset and inversion
// Ports:
//   clock     master clock
//   reset     synchronous active-low reset
//   active_i  controller is in RUN or STEP; output holds when low
//   cnt_i     current period counter
//   div_i     current divide ratio (>= 2)
//   offset_i  requested phase offset, clamped to div_i-1
//   invert_i  invert the output waveform
//   clk_o     registered derived clock
module clock_phase_chan
  import clock_phase_gen_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] offset_i,
  input  logic             invert_i,
  output logic             clk_o
);

  logic [CNT_W-1:0] div_m1;
  logic [CNT_W-1:0] off_eff;
  logic [CNT_W-1:0] shifted;
  logic             raw;
  logic             clk_q;

  always_comb begin
    div_m1  = div_i - CNT_W'(1);
    off_eff = (offset_i > div_m1) ? div_m1 : offset_i;
    shifted = CNT_W'(mod_sub(32'(cnt_i), 32'(off_eff), 32'(div_i)));
    // High for the first floor(div/2) counts after the channel's offset.
    raw     = (shifted < (div_i >> 1));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_q <= 1'b0;
    end else if (active_i) begin
      clk_q <= raw ^ invert_i;
    end
  end

  assign clk_o = clk_q;

endmodule

// File: rtl/clock_phase_gen.sv
// rtl/clock_phase_gen.sv - N_CH phase-offset derived clocks with run/halt/single-step control
// Ports:
//   clock        master clock, all logic on its rising edge
//   reset        synchronous active-low reset
//   en           free-run enable
//   div_ratio    requested divide ratio (clamped to >= 2)
//   phase_off    per-channel offsets, channel i at [i*CNT_W +: CNT_W]
//   invert       per-channel output inversion
//   step_req     single-period step request (level, sampled in IDLE)
//   step_ack     one-cycle pulse in the first IDLE cycle after a step
//   clk_out      registered derived clocks
//   phase_cnt    current period counter
//   cycle_start  registered pulse for count 0 of each active period
//   running      registered (state != IDLE)
module clock_phase_gen
  import clock_phase_gen_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 4,
  parameter int DIV_DEFAULT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [CNT_W-1:0]      div_ratio,
  input  logic [N_CH*CNT_W-1:0] phase_off,
  input  logic [N_CH-1:0]       invert,
  input  logic                  step_req,
  output logic                  step_ack,
  output logic [N_CH-1:0]       clk_out,
  output logic [CNT_W-1:0]      phase_cnt,
  output logic                  cycle_start,
  output logic                  running
);

  localparam logic [CNT_W-1:0] DIV_RST =
    (DIV_DEFAULT < DIV_MIN) ? CNT_W'(DIV_MIN) : CNT_W'(DIV_DEFAULT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_req;
  logic             step_ack_q, step_ack_d;
  logic             cycle_start_q, cycle_start_d;
  logic             running_q;
  logic             active, wrap, load_div;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: RUN and STEP only leave at wrap so periods are never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en)            state_d = RUN;
        else if (step_req) state_d = STEP;
      end
      RUN:     if (wrap && !en) state_d = IDLE;
      STEP:    if (wrap)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    active        = (state_q != IDLE);
    wrap          = active && (cnt_q == div_q - CNT_W'(1));
    div_req       = (div_ratio < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_ratio;
    load_div      = ((state_q == IDLE) && (state_d != IDLE)) || wrap;
    cnt_d         = (active && !wrap) ? cnt_q + CNT_W'(1) : '0;
    step_ack_d    = (state_q == STEP) && wrap;
    cycle_start_d = active && (cnt_q == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q         <= '0;
      div_q         <= DIV_RST;
      step_ack_q    <= 1'b0;
      cycle_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      if (load_div) div_q <= div_req;
      step_ack_q    <= step_ack_d;
      cycle_start_q <= cycle_start_d;
      running_q     <= active;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    clock_phase_chan #(.CNT_W(CNT_W)) u_chan (
      .clock    (clock),
      .reset    (reset),
      .active_i (active),
      .cnt_i    (cnt_q),
      .div_i    (div_q),
      .offset_i (phase_off[i*CNT_W +: CNT_W]),
      .invert_i (invert[i]),
      .clk_o    (clk_out[i])
    );
  end

  assign step_ack    = step_ack_q;
  assign phase_cnt   = cnt_q;
  assign cycle_start = cycle_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// tb/tb_clock_phase_gen.sv - directed self-checking bench for clock_phase_gen
module tb_clock_phase_gen;

  logic        clock;
  logic        reset;
  logic        en;
  logic [3:0]  div_ratio;
  logic [15:0] phase_off;
  logic [3:0]  invert;
  logic        step_req;
  logic        step_ack;
  logic [3:0]  clk_out;
  logic [3:0]  phase_cnt;
  logic        cycle_start;
  logic        running;

  int n_cmp = 0;
  int n_bad = 0;

  clock_phase_gen #(.N_CH(4), .CNT_W(4), .DIV_DEFAULT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .div_ratio   (div_ratio),
    .phase_off   (phase_off),
    .invert      (invert),
    .step_req    (step_req),
    .step_ack    (step_ack),
    .clk_out     (clk_out),
    .phase_cnt   (phase_cnt),
    .cycle_start (cycle_start),
    .running     (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; div_ratio = 4'd4; phase_off = '0; invert = '0; step_req = 1'b0;
    cyc(); cyc();
    n_cmp++; if (clk_out !== 4'b0000) begin n_bad++; $display("FAIL reset_clk_out got %b want 0000", clk_out); end
    n_cmp++; if (phase_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_phase_cnt got %0d want 0", phase_cnt); end
    n_cmp++; if ({step_ack, cycle_start, running} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {step_ack, cycle_start, running}); end
    reset = 1'b1;
    cyc();
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_first_running got %b want 0", running); end
    for (int j = 0; j < 8; j++) begin
      cyc();
      n_cmp++; if (clk_out[0] !== ((j % 4) < 2)) begin n_bad++; $display("FAIL run_clk0 j=%0d got %b want %b", j, clk_out[0], ((j % 4) < 2)); end
      n_cmp++; if (cycle_start !== ((j % 4) == 0)) begin n_bad++; $display("FAIL run_cycle_start j=%0d got %b want %b", j, cycle_start, ((j % 4) == 0)); end
      n_cmp++; if (phase_cnt !== 4'((j + 1) % 4)) begin n_bad++; $display("FAIL run_phase_cnt j=%0d got %0d want %0d", j, phase_cnt, (j + 1) % 4); end
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL run_running j=%0d got %b want 1", j, running); end
    end
  endtask

  task automatic test_phase();
    logic [3:0] tbl [4];
    tbl[0] = 4'b1011; tbl[1] = 4'b0001; tbl[2] = 4'b0100; tbl[3] = 4'b1110;
    reset = 1'b0; en = 1'b1; div_ratio = 4'd4;
    phase_off = {4'd3, 4'd2, 4'd1, 4'd0}; invert = 4'b0010;
    cyc(); reset = 1'b1; cyc();
    for (int j = 0; j < 8; j++) begin
      cyc();
      n_cmp++; if (clk_out !== tbl[j % 4]) begin n_bad++; $display("FAIL phase_clk_out j=%0d got %b want %b", j, clk_out, tbl[j % 4]); end
    end
  endtask

  task automatic test_halt();
    reset = 1'b0; en = 1'b1; div_ratio = 4'd6; phase_off = '0; invert = 4'b0001;
    cyc(); reset = 1'b1; cyc(); cyc();
    n_cmp++; if (phase_cnt !== 4'd1) begin n_bad++; $display("FAIL halt_pre_cnt got %0d want 1", phase_cnt); end
    en = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      cyc();
      n_cmp++; if (phase_cnt !== 4'(k - 1)) begin n_bad++; $display("FAIL halt_finish_cnt k=%0d got %0d want %0d", k, phase_cnt, k - 1); end
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL halt_finish_running k=%0d got %b want 1", k, running); end
    end
    cyc();
    n_cmp++; if ({phase_cnt, running, clk_out} !== {4'd0, 1'b1, 4'b0001}) begin n_bad++; $display("FAIL halt_wrap got cnt=%0d run=%b clk=%b want cnt=0 run=1 clk=0001", phase_cnt, running, clk_out); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_cmp++; if ({phase_cnt, running, cycle_start, clk_out} !== {4'd0, 1'b0, 1'b0, 4'b0001}) begin n_bad++; $display("FAIL halt_idle k=%0d got cnt=%0d run=%b cs=%b clk=%b want cnt=0 run=0 cs=0 clk=0001", k, phase_cnt, running, cycle_start, clk_out); end
    end
  endtask

  task automatic test_step();
    int act;
    act = 0;
    invert = '0; div_ratio = 4'd5; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    n_cmp++; if ({running, phase_cnt} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL step_entry got run=%b cnt=%0d want run=0 cnt=0", running, phase_cnt); end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (running === 1'b1) act++;
      n_cmp++; if (clk_out[0] !== (k <= 2)) begin n_bad++; $display("FAIL step_clk0 k=%0d got %b want %b", k, clk_out[0], (k <= 2)); end
      n_cmp++; if (step_ack !== (k == 5)) begin n_bad++; $display("FAIL step_ack k=%0d got %b want %b", k, step_ack, (k == 5)); end
      n_cmp++; if (phase_cnt !== ((k < 5) ? 4'(k) : 4'd0)) begin n_bad++; $display("FAIL step_cnt k=%0d got %0d want %0d", k, phase_cnt, (k < 5) ? k : 0); end
      n_cmp++; if (cycle_start !== (k == 1)) begin n_bad++; $display("FAIL step_cycle_start k=%0d got %b want %b", k, cycle_start, (k == 1)); end
    end
    n_cmp++; if (act !== 5) begin n_bad++; $display("FAIL step_active_cycles got %0d want 5", act); end
  endtask

  task automatic test_div_change();
    reset = 1'b0; en = 1'b1; div_ratio = 4'd4; invert = '0;
    phase_off = {4'd0, 4'd0, 4'd9, 4'd0};
    cyc(); reset = 1'b1; cyc(); cyc();
    div_ratio = 4'd8;
    cyc();
    n_cmp++; if (phase_cnt !== 4'd2) begin n_bad++; $display("FAIL div_cur_period a got %0d want 2", phase_cnt); end
    cyc();
    n_cmp++; if (phase_cnt !== 4'd3) begin n_bad++; $display("FAIL div_cur_period b got %0d want 3", phase_cnt); end
    cyc();
    n_cmp++; if (phase_cnt !== 4'd0) begin n_bad++; $display("FAIL div_cur_period wrap got %0d want 0", phase_cnt); end
    div_ratio = 4'd1;
    for (int j = 0; j < 8; j++) begin
      cyc();
      n_cmp++; if (phase_cnt !== 4'((j + 1) % 8)) begin n_bad++; $display("FAIL div8_cnt j=%0d got %0d want %0d", j, phase_cnt, (j + 1) % 8); end
      n_cmp++; if (clk_out[1:0] !== {(j <= 2 || j == 7), (j < 4)}) begin n_bad++; $display("FAIL div8_clk j=%0d got %b want %b", j, clk_out[1:0], {(j <= 2 || j == 7), (j < 4)}); end
    end
    for (int j = 0; j < 4; j++) begin
      cyc();
      n_cmp++; if (phase_cnt !== 4'((j + 1) % 2)) begin n_bad++; $display("FAIL div2_cnt j=%0d got %0d want %0d", j, phase_cnt, (j + 1) % 2); end
      n_cmp++; if (clk_out[1:0] !== {((j % 2) == 1), ((j % 2) == 0)}) begin n_bad++; $display("FAIL div2_clk j=%0d got %b want %b", j, clk_out[1:0], {((j % 2) == 1), ((j % 2) == 0)}); end
    end
  endtask

  task automatic test_reset_during_step();
    reset = 1'b0; en = 1'b0; phase_off = '0; invert = '0;
    cyc();
    reset = 1'b1; div_ratio = 4'd5; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    cyc(); cyc();
    n_cmp++; if ({phase_cnt, clk_out} !== {4'd2, 4'b1111}) begin n_bad++; $display("FAIL rstep_pre got cnt=%0d clk=%b want cnt=2 clk=1111", phase_cnt, clk_out); end
    reset = 1'b0;
    cyc();
    n_cmp++; if ({clk_out, phase_cnt, step_ack, cycle_start, running} !== 11'd0) begin n_bad++; $display("FAIL rstep_reset got clk=%b cnt=%0d ack=%b cs=%b run=%b want all 0", clk_out, phase_cnt, step_ack, cycle_start, running); end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_cmp++; if ({step_ack, running, phase_cnt} !== 6'd0) begin n_bad++; $display("FAIL rstep_after k=%0d got ack=%b run=%b cnt=%0d want 0 0 0", k, step_ack, running, phase_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    div_ratio = 4'd2; step_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_cmp++; if (running !== ((k % 3) != 0)) begin n_bad++; $display("FAIL b2b_running k=%0d got %b want %b", k, running, ((k % 3) != 0)); end
      n_cmp++; if (step_ack !== (k == 2 || k == 5)) begin n_bad++; $display("FAIL b2b_ack k=%0d got %b want %b", k, step_ack, (k == 2 || k == 5)); end
    end
    step_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; div_ratio = 4'd4; phase_off = '0; invert = '0; step_req = 1'b0;
    test_reset();
    test_phase();
    test_halt();
    test_step();
    test_div_change();
    test_reset_during_step();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_phase_gen.md
Name: clock_phase_gen

Overview:
Parametrised successor to the fixed clock_divider. It produces N_CH derived clock outputs from the single master clock, each with a shared runtime-programmable divide ratio, a per-channel phase offset and a per-channel inversion. It adds a run/halt/single-step controller with a request/acknowledge handshake, so the bench can advance the processor/imem/dmem/regfile clock domains one full period at a time. It sits at the top level in place of the fixed divider.

Parameters:
- N_CH, 4, number of derived clock outputs.
- CNT_W, 4, width of the period counter, divide ratio and offsets.
- DIV_DEFAULT, 4, divide ratio loaded at reset.

Ports:
- clock  in  1  master clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  free-run enable.
- div_ratio  in  CNT_W  requested divide ratio.
- phase_off  in  N_CH*CNT_W  per-channel offset; channel i uses bits [i*CNT_W +: CNT_W].
- invert  in  N_CH  per-channel output inversion.
- step_req  in  1  single-period step request.
- step_ack  out  1  one-cycle pulse when a step completes.
- clk_out  out  N_CH  derived clocks (registered).
- phase_cnt  out  CNT_W  current period counter.
- cycle_start  out  1  registered pulse aligned with count 0 of each active period.
- running  out  1  high in RUN or STEP.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, cnt=0, div_q=max(DIV_DEFAULT,2).
  - clk_out=0, step_ack=0, cycle_start=0, running=0.
  - Reset overrides any activity in progress.
- div_q update: div_q = max(div_ratio,2). It is sampled only at reset, on IDLE->RUN/STEP entry, and at wrap (cnt==div_q-1 while active). It never changes mid-period.
- Effective offset: off_i = min(phase_off_i, div_q-1).
- Counter: while in RUN or STEP, cnt increments and wraps from div_q-1 to 0. In IDLE, cnt is held at 0.
- Channel waveform: s_i = (cnt - off_i) mod div_q; raw_i = (s_i < div_q>>1). A period therefore has floor(div_q/2) high counts.
- Output register: clk_out[i] <= raw_i ^ invert[i], registered with 1-cycle latency from cnt. In IDLE, clk_out holds its last value.
- cycle_start <= active && cnt==0.
- State machine:
  - IDLE -> RUN: en==1. en has priority over step_req.
  - IDLE -> STEP: en==0 && step_req==1.
  - RUN: on en==0, the current period is finished. RUN -> IDLE occurs at wrap only, so periods are never truncated.
  - STEP: runs exactly div_q cycles. STEP -> IDLE at wrap, with step_ack=1 in the cycle after that wrap edge (the first IDLE cycle).
  - step_req is ignored in RUN and STEP. It is level-sampled in IDLE only, so a held request yields back-to-back steps separated by one IDLE cycle.
  - en rising during STEP: STEP completes (ack issued), then the controller enters RUN from IDLE on the next evaluation.
- running is a registered copy of (state!=IDLE).
- No combinational paths from inputs to outputs.

Decomposition:
- Package clock_phase_gen_pkg:
  - state enum {IDLE, RUN, STEP}
  - constant DIV_MIN=2
  - helper function for modular subtraction in CNT_W bits.
- Sub-module clock_phase_chan: one instance per channel. Inputs cnt, div_q, offset, invert; output is the registered clk_out bit. It is instantiated N_CH times with a generate loop.
- The top level holds the counter, div_q and the FSM.

Test Plan:
- Reset with en=1, div_ratio=4, offsets=0, invert=0 -> after reset release, clk_out[0] pattern is 1,1,0,0 repeating; cycle_start every 4th cycle; running=1.
- div_ratio=4, phase_off={3,2,1,0}, invert=4'b0010 -> channels are quarter-period staggered; channel 1 is the complement of its un-inverted waveform. This reproduces the legacy four-clock skeleton timing.
- en=0 mid-period at cnt=1, div=6 -> counting continues to cnt=5, then IDLE; clk_out frozen; phase_cnt=0; running=0 one cycle later.
- IDLE, pulse step_req, div=5 -> exactly 5 active cycles; clk_out[0] high for 2 counts; step_ack single pulse; no further activity.
- Change div_ratio 4->8 at cnt=1, and div_ratio=1 -> the current period stays at 4; the next period is 8. Ratio 1 is clamped to 2 (period 2, duty 1/2). phase_off=9 with div=8 behaves as 7.
- Assert reset (low) during STEP at cnt=2 -> next cycle all outputs are 0, state IDLE; no step_ack is issued.
